// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch/decode types, field positions and opcode constants
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_KILL = 2'd3
  } fetch_state_t;

  // Next-PC source chosen by the fetch FSM each cycle
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_PENDING  = 2'd3
  } pc_sel_t;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 27;
  localparam int WORD_BYTES = 4;

  localparam logic [4:0] OP_J    = 5'b00000;
  localparam logic [4:0] OP_JAL  = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b11000;
  localparam logic [4:0] OP_BEQ  = 5'b11100;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - PC and pending-redirect registers with alignment and misalign flag
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       PC_STEP  = WORD_BYTES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  pc_sel_t          i_sel,
  input  logic             i_pend_load,
  input  logic             i_redirect_valid,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_misalign_err
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_pc;
  logic             r_misalign_err;
  logic [WIDTH-1:0] w_redirect_aligned;
  logic [WIDTH-1:0] w_pc_nxt;

  // Targets are always word-aligned; the dropped bits only raise the flag
  assign w_redirect_aligned = {i_redirect_pc[WIDTH-1:2], 2'b00};

  // Next-PC mux; increment wraps naturally at 2^WIDTH
  always_comb begin
    w_pc_nxt = r_pc;
    case (i_sel)
      PC_HOLD:     w_pc_nxt = r_pc;
      PC_INC:      w_pc_nxt = r_pc + WIDTH'(PC_STEP);
      PC_REDIRECT: w_pc_nxt = w_redirect_aligned;
      PC_PENDING:  w_pc_nxt = r_pend_pc;
      default:     w_pc_nxt = r_pc;
    endcase
  end

  // PC, pending target and sticky misalign flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc           <= RESET_PC;
      r_pend_pc      <= RESET_PC;
      r_misalign_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (i_pend_load) begin
        r_pend_pc <= w_redirect_aligned;
      end
      if (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) begin
        r_misalign_err <= 1'b1;
      end
    end
  end

  assign o_pc           = r_pc;
  assign o_misalign_err = r_misalign_err;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with redirect squash and instruction register
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned      PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] instr,
  output logic [4:0]       op,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             misalign_err
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_instr;
  pc_sel_t          w_pc_sel;
  logic             w_pend_load;
  logic             w_instr_load;
  logic             w_req;
  logic             w_valid;
  logic [WIDTH-1:0] w_pc;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_sel            (w_pc_sel),
    .i_pend_load      (w_pend_load),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc             (w_pc),
    .o_misalign_err   (misalign_err)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; redirect outranks ack and dec_ready everywhere
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = imem_ack ? S_REQ : S_KILL;
        end else if (imem_ack) begin
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect_valid || dec_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      S_KILL: begin
        if (imem_ack) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state outputs and PC / instruction register controls
  always_comb begin
    w_pc_sel     = PC_HOLD;
    w_pend_load  = 1'b0;
    w_instr_load = 1'b0;
    w_req        = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid) w_pc_sel = PC_REDIRECT;
      end
      S_REQ: begin
        w_req = 1'b1;
        if (redirect_valid) begin
          // Same-cycle ack means nothing stays in flight, so no kill needed
          if (imem_ack) w_pc_sel = PC_REDIRECT;
          else          w_pend_load = 1'b1;
        end else if (imem_ack) begin
          w_instr_load = 1'b1;
        end
      end
      S_FULL: begin
        w_valid = 1'b1;
        if (redirect_valid)  w_pc_sel = PC_REDIRECT;
        else if (dec_ready)  w_pc_sel = PC_INC;
      end
      S_KILL: begin
        // Address stays on the old PC until the stale response drains
        w_req = 1'b1;
        if (imem_ack) begin
          w_pc_sel = redirect_valid ? PC_REDIRECT : PC_PENDING;
        end else if (redirect_valid) begin
          w_pend_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Instruction register, loaded only by a non-squashed response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr <= '0;
    end else if (w_instr_load) begin
      r_instr <= imem_rdata;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = w_pc;
  assign instr_valid = w_valid;
  assign instr       = r_instr;
  assign op          = r_instr[OP_MSB:OP_LSB];
  assign pc          = w_pc;
  assign pc_plus     = w_pc + WIDTH'(PC_STEP);

endmodule
